// File: rtl/bpu_resolve_ctrl_if.sv
// Resolution bus between the execute lanes and the branch resolve controller.
// Master drives the two resolve lanes; slave returns PHT updates, recovery and statistics.
interface bpu_resolve_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             res_valid1;
  logic             res_valid2;
  logic             res_is_branch1;
  logic             res_is_branch2;
  logic             res_pred1;
  logic             res_pred2;
  logic             res_actual1;
  logic             res_actual2;
  logic [7:0]       res_addr1;
  logic [7:0]       res_addr2;
  logic [4:0]       res_ghr1;
  logic [4:0]       res_ghr2;
  logic [7:0]       res_target1;
  logic [7:0]       res_target2;
  logic [7:0]       res_next1;
  logic [7:0]       res_next2;

  logic             update_signal1;
  logic             update_signal2;
  logic             actual_outcome1;
  logic             actual_outcome2;
  logic [7:0]       branch_address_E1;
  logic [7:0]       branch_address_E2;
  logic [4:0]       ghr_E1;
  logic [4:0]       ghr_E2;
  logic             flush;
  logic             redirect_valid;
  logic [7:0]       redirect_pc;
  logic             stall_fetch;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output res_valid1, res_valid2, res_is_branch1, res_is_branch2,
           res_pred1, res_pred2, res_actual1, res_actual2,
           res_addr1, res_addr2, res_ghr1, res_ghr2,
           res_target1, res_target2, res_next1, res_next2,
    input  update_signal1, update_signal2, actual_outcome1, actual_outcome2,
           branch_address_E1, branch_address_E2, ghr_E1, ghr_E2,
           flush, redirect_valid, redirect_pc, stall_fetch,
           branch_count, mispredict_count
  );

  modport slave (
    input  res_valid1, res_valid2, res_is_branch1, res_is_branch2,
           res_pred1, res_pred2, res_actual1, res_actual2,
           res_addr1, res_addr2, res_ghr1, res_ghr2,
           res_target1, res_target2, res_next1, res_next2,
    output update_signal1, update_signal2, actual_outcome1, actual_outcome2,
           branch_address_E1, branch_address_E2, ghr_E1, ghr_E2,
           flush, redirect_valid, redirect_pc, stall_fetch,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/bpu_resolve_ctrl.sv
// Dual-lane branch resolve controller: trains the PHT from resolved branches,
// detects mispredicts, sequences flush/redirect/refill recovery and keeps statistics.
module bpu_resolve_ctrl #(
  parameter int unsigned REFILL_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  bpu_resolve_ctrl_if.slave   io_bus
);

  typedef enum logic [1:0] {StIdle, StFlush, StRefill} state_e;

  localparam logic [3:0] RefillLoad = 4'(REFILL_CYCLES);

  state_e           r_state;
  state_e           w_state_next;
  logic [3:0]       r_refill_cnt;
  logic [3:0]       w_refill_cnt_next;

  logic             r_upd1, r_upd2;
  logic             r_out1, r_out2;
  logic [7:0]       r_addr1, r_addr2;
  logic [4:0]       r_ghr1, r_ghr2;
  logic [7:0]       r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_idle;
  logic             w_acc1, w_acc2;
  logic             w_mis1, w_mis2, w_mis;
  logic [7:0]       w_redirect_pc;
  logic [CNT_W:0]   w_bc_sum;
  logic [CNT_W-1:0] w_bc_next;
  logic [CNT_W-1:0] w_mc_next;

  // Lane acceptance; an older-lane mispredict squashes the younger lane.
  always_comb begin
    w_idle = (r_state == StIdle);
    w_acc1 = w_idle & io_bus.res_valid1 & io_bus.res_is_branch1;
    w_mis1 = w_acc1 & (io_bus.res_pred1 != io_bus.res_actual1);
    w_acc2 = w_idle & io_bus.res_valid2 & io_bus.res_is_branch2 & ~w_mis1;
    w_mis2 = w_acc2 & (io_bus.res_pred2 != io_bus.res_actual2);
    w_mis  = w_mis1 | w_mis2;
    if (w_mis1) begin
      w_redirect_pc = io_bus.res_actual1 ? io_bus.res_target1 : io_bus.res_next1;
    end else if (w_mis2) begin
      w_redirect_pc = io_bus.res_actual2 ? io_bus.res_target2 : io_bus.res_next2;
    end else begin
      w_redirect_pc = '0;
    end
  end

  // Saturating statistics next-state.
  always_comb begin
    w_bc_sum  = {1'b0, r_branch_cnt} + (CNT_W+1)'(w_acc1) + (CNT_W+1)'(w_acc2);
    w_bc_next = w_bc_sum[CNT_W] ? {CNT_W{1'b1}} : w_bc_sum[CNT_W-1:0];
    w_mc_next = r_mispred_cnt;
    if (w_mis && (r_mispred_cnt != {CNT_W{1'b1}})) begin
      w_mc_next = r_mispred_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Recovery FSM next-state and refill down-counter.
  always_comb begin
    w_state_next      = r_state;
    w_refill_cnt_next = r_refill_cnt;
    case (r_state)
      StIdle: begin
        if (w_mis) w_state_next = StFlush;
      end
      StFlush: begin
        w_state_next      = StRefill;
        w_refill_cnt_next = RefillLoad;
      end
      StRefill: begin
        // Leave on the last stalled cycle so REFILL lasts exactly RefillLoad cycles.
        if (r_refill_cnt <= 4'd1) begin
          w_state_next      = StIdle;
          w_refill_cnt_next = '0;
        end else begin
          w_refill_cnt_next = r_refill_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next      = StIdle;
        w_refill_cnt_next = '0;
      end
    endcase
  end

  // State, update pipeline register and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_refill_cnt  <= '0;
      r_upd1        <= 1'b0;
      r_upd2        <= 1'b0;
      r_out1        <= 1'b0;
      r_out2        <= 1'b0;
      r_addr1       <= '0;
      r_addr2       <= '0;
      r_ghr1        <= '0;
      r_ghr2        <= '0;
      r_redirect_pc <= '0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_state       <= w_state_next;
      r_refill_cnt  <= w_refill_cnt_next;
      r_upd1        <= w_acc1;
      r_upd2        <= w_acc2;
      r_out1        <= w_acc1 & io_bus.res_actual1;
      r_out2        <= w_acc2 & io_bus.res_actual2;
      r_addr1       <= w_acc1 ? io_bus.res_addr1 : 8'h00;
      r_addr2       <= w_acc2 ? io_bus.res_addr2 : 8'h00;
      r_ghr1        <= w_acc1 ? io_bus.res_ghr1 : 5'h00;
      r_ghr2        <= w_acc2 ? io_bus.res_ghr2 : 5'h00;
      r_redirect_pc <= w_redirect_pc;
      r_branch_cnt  <= w_bc_next;
      r_mispred_cnt <= w_mc_next;
    end
  end

  // Output drive; recovery flags decode directly from the registered state.
  always_comb begin
    io_bus.update_signal1    = r_upd1;
    io_bus.update_signal2    = r_upd2;
    io_bus.actual_outcome1   = r_out1;
    io_bus.actual_outcome2   = r_out2;
    io_bus.branch_address_E1 = r_addr1;
    io_bus.branch_address_E2 = r_addr2;
    io_bus.ghr_E1            = r_ghr1;
    io_bus.ghr_E2            = r_ghr2;
    io_bus.flush             = (r_state == StFlush);
    io_bus.redirect_valid    = (r_state == StFlush);
    io_bus.redirect_pc       = (r_state == StFlush) ? r_redirect_pc : 8'h00;
    io_bus.stall_fetch       = (r_state != StIdle);
    io_bus.branch_count      = r_branch_cnt;
    io_bus.mispredict_count  = r_mispred_cnt;
  end

endmodule

// File: tb/tb_bpu_resolve_ctrl.sv
// Directed self-checking bench for bpu_resolve_ctrl with hand-computed expectations.
module tb_bpu_resolve_ctrl;

  localparam int unsigned CNT_W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  bpu_resolve_ctrl_if #(.CNT_W(CNT_W)) bus ();

  bpu_resolve_ctrl #(
    .REFILL_CYCLES(2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic clear_inputs();
    bus.res_valid1 = 0; bus.res_valid2 = 0;
    bus.res_is_branch1 = 0; bus.res_is_branch2 = 0;
    bus.res_pred1 = 0; bus.res_pred2 = 0;
    bus.res_actual1 = 0; bus.res_actual2 = 0;
    bus.res_addr1 = 0; bus.res_addr2 = 0;
    bus.res_ghr1 = 0; bus.res_ghr2 = 0;
    bus.res_target1 = 0; bus.res_target2 = 0;
    bus.res_next1 = 0; bus.res_next2 = 0;
  endtask

  task automatic lane1(input logic p, input logic a, input logic [7:0] addr,
                       input logic [4:0] ghr, input logic [7:0] tgt, input logic [7:0] nxt);
    bus.res_valid1 = 1; bus.res_is_branch1 = 1; bus.res_pred1 = p; bus.res_actual1 = a;
    bus.res_addr1 = addr; bus.res_ghr1 = ghr; bus.res_target1 = tgt; bus.res_next1 = nxt;
  endtask

  task automatic lane2(input logic p, input logic a, input logic [7:0] addr,
                       input logic [4:0] ghr, input logic [7:0] tgt, input logic [7:0] nxt);
    bus.res_valid2 = 1; bus.res_is_branch2 = 1; bus.res_pred2 = p; bus.res_actual2 = a;
    bus.res_addr2 = addr; bus.res_ghr2 = ghr; bus.res_target2 = tgt; bus.res_next2 = nxt;
  endtask

  // Caller is at a negedge; advance one active edge and land on the next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_upd1"},  32'(bus.update_signal1), 0);
    check_eq({tag, "_upd2"},  32'(bus.update_signal2), 0);
    check_eq({tag, "_addr1"}, 32'(bus.branch_address_E1), 0);
    check_eq({tag, "_addr2"}, 32'(bus.branch_address_E2), 0);
    check_eq({tag, "_flush"}, 32'(bus.flush), 0);
    check_eq({tag, "_rpc"},   32'(bus.redirect_pc), 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    step();
    check_eq("rst_stall", 32'(bus.stall_fetch), 0);
    check_eq("rst_bc", 32'(bus.branch_count), 0);
    check_eq("rst_mc", 32'(bus.mispredict_count), 0);
    check_quiet("rst");
    rst = 1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    rst = 0;
    @(negedge clk);
    do_reset();

    // Correct taken branch on lane 1.
    lane1(1, 1, 8'h12, 5'h05, 8'h77, 8'h13);
    step();
    clear_inputs();
    check_eq("c1_upd1", 32'(bus.update_signal1), 1);
    check_eq("c1_upd2", 32'(bus.update_signal2), 0);
    check_eq("c1_out1", 32'(bus.actual_outcome1), 1);
    check_eq("c1_addr1", 32'(bus.branch_address_E1), 32'h12);
    check_eq("c1_ghr1", 32'(bus.ghr_E1), 32'h05);
    check_eq("c1_flush", 32'(bus.flush), 0);
    check_eq("c1_stall", 32'(bus.stall_fetch), 0);
    check_eq("c1_bc", 32'(bus.branch_count), 1);
    step();
    check_quiet("c1_after");

    // Non-branch resolutions are ignored.
    bus.res_valid1 = 1; bus.res_valid2 = 1; bus.res_addr1 = 8'h44;
    step();
    clear_inputs();
    check_quiet("nb");
    check_eq("nb_bc", 32'(bus.branch_count), 1);

    // Lane 1 mispredict squashes lane 2; full recovery sequence.
    do_reset();
    lane1(0, 1, 8'h30, 5'h0A, 8'h40, 8'h31);
    lane2(1, 1, 8'h31, 5'h0B, 8'h50, 8'h32);
    step();
    clear_inputs();
    check_eq("m1_upd1", 32'(bus.update_signal1), 1);
    check_eq("m1_upd2", 32'(bus.update_signal2), 0);
    check_eq("m1_out1", 32'(bus.actual_outcome1), 1);
    check_eq("m1_addr2", 32'(bus.branch_address_E2), 0);
    check_eq("m1_flush", 32'(bus.flush), 1);
    check_eq("m1_rv", 32'(bus.redirect_valid), 1);
    check_eq("m1_rpc", 32'(bus.redirect_pc), 32'h40);
    check_eq("m1_stall", 32'(bus.stall_fetch), 1);
    check_eq("m1_mc", 32'(bus.mispredict_count), 1);
    check_eq("m1_bc", 32'(bus.branch_count), 1);
    step();
    check_eq("m1_r1_stall", 32'(bus.stall_fetch), 1);
    check_eq("m1_r1_rv", 32'(bus.redirect_valid), 0);
    check_quiet("m1_r1");
    step();
    check_eq("m1_r2_stall", 32'(bus.stall_fetch), 1);
    step();
    check_eq("m1_idle_stall", 32'(bus.stall_fetch), 0);
    check_eq("m1_idle_flush", 32'(bus.flush), 0);

    // Lane 2 mispredict with lane 1 correct: both train, redirect from lane 2.
    do_reset();
    lane1(1, 1, 8'h10, 5'h03, 8'h60, 8'h11);
    lane2(1, 0, 8'h20, 5'h1F, 8'h55, 8'h21);
    step();
    clear_inputs();
    check_eq("m2_upd1", 32'(bus.update_signal1), 1);
    check_eq("m2_upd2", 32'(bus.update_signal2), 1);
    check_eq("m2_out2", 32'(bus.actual_outcome2), 0);
    check_eq("m2_addr2", 32'(bus.branch_address_E2), 32'h20);
    check_eq("m2_ghr2", 32'(bus.ghr_E2), 32'h1F);
    check_eq("m2_rpc", 32'(bus.redirect_pc), 32'h21);
    check_eq("m2_flush", 32'(bus.flush), 1);
    check_eq("m2_bc", 32'(bus.branch_count), 2);
    check_eq("m2_mc", 32'(bus.mispredict_count), 1);

    // Wrong-path resolutions during FLUSH and REFILL are discarded.
    do_reset();
    lane1(1, 0, 8'h05, 5'h01, 8'h70, 8'h08);
    step();
    check_eq("wp_flush", 32'(bus.flush), 1);
    check_eq("wp_rpc", 32'(bus.redirect_pc), 32'h08);
    clear_inputs();
    lane1(1, 1, 8'h66, 5'h02, 8'h00, 8'h00);
    lane2(0, 0, 8'h67, 5'h03, 8'h00, 8'h00);
    step();
    check_eq("wp_r1_upd1", 32'(bus.update_signal1), 0);
    check_eq("wp_r1_upd2", 32'(bus.update_signal2), 0);
    step();
    check_eq("wp_r2_upd1", 32'(bus.update_signal1), 0);
    check_eq("wp_r2_stall", 32'(bus.stall_fetch), 1);
    step();
    clear_inputs();
    check_eq("wp_idle_upd1", 32'(bus.update_signal1), 0);
    check_eq("wp_idle_upd2", 32'(bus.update_signal2), 0);
    check_eq("wp_idle_stall", 32'(bus.stall_fetch), 0);
    check_eq("wp_bc", 32'(bus.branch_count), 1);
    check_eq("wp_mc", 32'(bus.mispredict_count), 1);

    // Reset asserted mid-REFILL aborts recovery immediately.
    do_reset();
    lane1(0, 1, 8'h09, 5'h04, 8'h90, 8'h0A);
    step();
    clear_inputs();
    step();
    check_eq("ar_pre_stall", 32'(bus.stall_fetch), 1);
    #2 rst = 0;
    #1;
    check_eq("ar_stall", 32'(bus.stall_fetch), 0);
    check_eq("ar_mc", 32'(bus.mispredict_count), 0);
    check_eq("ar_bc", 32'(bus.branch_count), 0);
    check_quiet("ar");
    @(negedge clk);
    rst = 1;
    step();
    check_eq("ar_rel_stall", 32'(bus.stall_fetch), 0);
    check_eq("ar_rel_rv", 32'(bus.redirect_valid), 0);
    lane1(0, 0, 8'h2C, 5'h11, 8'h00, 8'h2D);
    step();
    clear_inputs();
    check_eq("ar_new_upd1", 32'(bus.update_signal1), 1);
    check_eq("ar_new_addr1", 32'(bus.branch_address_E1), 32'h2C);
    check_eq("ar_new_ghr1", 32'(bus.ghr_E1), 32'h11);
    check_eq("ar_new_flush", 32'(bus.flush), 0);
    check_eq("ar_new_bc", 32'(bus.branch_count), 1);

    // Preload branch_count to max-1 with dual correct resolutions, then saturate.
    do_reset();
    lane1(1, 1, 8'h01, 5'h00, 8'h00, 8'h00);
    lane2(0, 0, 8'h02, 5'h00, 8'h00, 8'h00);
    for (int i = 0; i < 32767; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("sat_pre", 32'(bus.branch_count), 32'hFFFE);
    step();
    check_eq("sat_max", 32'(bus.branch_count), 32'hFFFF);
    step();
    clear_inputs();
    check_eq("sat_hold", 32'(bus.branch_count), 32'hFFFF);
    check_eq("sat_mc", 32'(bus.mispredict_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bpu_resolve_ctrl.md
BPU_RESOLVE_CTRL -- requirements
Module: bpu_resolve_ctrl

Interface
REQ-001 Parameter REFILL_CYCLES, default 2: cycles fetch stays stalled after a flush (legal range 1..15).
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 clk  in  1  Single clock; all state changes on its rising edge.
REQ-004 rst  in  1  Reset, asynchronous, active-low; low clears all state immediately.
REQ-005 res_valid1, res_valid2  in  1 each  Lane resolves an instruction this cycle; lane 1 is older than lane 2.
REQ-006 res_is_branch1, res_is_branch2  in  1 each  Resolved instruction is a conditional branch.
REQ-007 res_pred1, res_pred2  in  1 each  Direction predicted at fetch (1 = taken).
REQ-008 res_actual1, res_actual2  in  1 each  Direction computed in execute.
REQ-009 res_addr1, res_addr2  in  8 each  Branch instruction address.
REQ-010 res_ghr1, res_ghr2  in  5 each  GHR snapshot carried from fetch.
REQ-011 res_target1, res_target2  in  8 each  Taken target address.
REQ-012 res_next1, res_next2  in  8 each  Fall-through address.
REQ-013 update_signal1, update_signal2  out  1 each  One-cycle PHT update strobes.
REQ-014 actual_outcome1, actual_outcome2  out  1 each  Outcome to train.
REQ-015 branch_address_E1, branch_address_E2  out  8 each  PHT update index address.
REQ-016 ghr_E1, ghr_E2  out  5 each  GHR used for the update and for GHR repair.
REQ-017 flush  out  1  Squash all younger in-flight instructions.
REQ-018 redirect_valid  out  1  Fetch must load redirect_pc.
REQ-019 redirect_pc  out  8  Correct fetch address.
REQ-020 stall_fetch  out  1  Fetch holds during recovery.
REQ-021 branch_count, mispredict_count  out  CNT_W each  Saturating statistics counters.

Function
REQ-022 FSM states: IDLE, FLUSH, REFILL; only IDLE accepts resolutions.
REQ-023 In IDLE, lane k is accepted when res_valid_k=1 and res_is_branch_k=1; non-branch resolutions are ignored.
REQ-024 An accepted lane k is a mispredict when res_pred_k != res_actual_k.
REQ-025 If lane 1 is accepted and mispredicts, lane 2 is squashed: no update, no count, no redirect from lane 2.
REQ-026 Each accepted, unsquashed lane k drives update_signal_k=1 for exactly one cycle, one cycle after sampling, with actual_outcome_k, branch_address_E_k, and ghr_E_k registered from that lane's inputs.
REQ-027 On the first unsquashed mispredict, the FSM goes IDLE->FLUSH on the same edge that registers the updates.
REQ-028 In FLUSH (exactly 1 cycle): flush=1, redirect_valid=1, stall_fetch=1, redirect_pc = res_target if actual taken, else res_next, taken from the mispredicting lane.
REQ-029 FLUSH->REFILL unconditionally; REFILL holds stall_fetch=1 for REFILL_CYCLES cycles using a down-counter, then returns to IDLE.
REQ-030 Resolutions presented in FLUSH or REFILL are wrong-path: they are discarded, with no update and no count.
REQ-031 branch_count increments by the number of accepted, unsquashed lanes (0, 1, or 2) and saturates at all-ones.
REQ-032 mispredict_count increments by 1 per recovery entered and saturates at all-ones.
REQ-033 Outputs not asserted per REQ-026 or REQ-028 are 0; the address, ghr, and redirect_pc buses are 0 when their strobe is 0.
REQ-034 A lane 2 mispredict with lane 1 correct updates both lanes and redirects from lane 2.

Reset
REQ-035 While rst=0: state=IDLE, REFILL counter=0, all strobes, flags, and buses=0, and both counters=0.
REQ-036 rst asserted during FLUSH or REFILL aborts recovery; after release the block is in IDLE with stall_fetch=0 and no pending redirect.

Verification
REQ-037 Lane 1 valid branch, pred=1, actual=1, addr=0x12, ghr=0x05 -> next cycle update_signal1=1, branch_address_E1=0x12, ghr_E1=0x05, flush=0, branch_count=1.
REQ-038 Lane 1 pred=0, actual=1, target=0x40; lane 2 also valid -> update1 only, FLUSH with redirect_pc=0x40, then stall_fetch=1 for 2 cycles, IDLE; mispredict_count=1, branch_count=1.
REQ-039 Lane 1 correct; lane 2 pred=1, actual=0, next=0x21 -> both updates pulse, redirect_pc=0x21, branch_count=2.
REQ-040 Mispredict, then valid correct resolutions during REFILL -> no update strobes, counters unchanged by the discarded resolutions.
REQ-041 Preload branch_count to max-1, then resolve two branches -> count holds at all-ones.
REQ-042 rst low in the middle of REFILL -> all outputs 0 immediately; after release, a new correct branch is accepted normally.
